alu_wb_stage: RTL and testbench

//  Writeback/status stage directly downstream of the 20-bit ALU. Takes one ALU result per

---
 rtl/alu_wb_stage.sv | 174 +++++++++++++++++
 tb/tb_alu_wb_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Writeback/status stage behind the 20-bit ALU: RF write port, {carry,sign,zero} status, jump resolution.
// Optional feature macro: ALU_WB_PERF_EN adds saturating RF-write and taken-jump counters.
module alu_wb_stage #(
    parameter int WORD_W = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_mode,
    input  logic [WORD_W-1:0] in_result,
    input  logic [WORD_W-1:0] in_result2,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_dst2,
    input  logic              in_zero,
    input  logic              in_sign,
    input  logic              in_carry,
    input  logic              in_flag_we,
    input  logic [1:0]        in_cond,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [WORD_W-1:0] rf_wdata,
    output logic [2:0]        status,
    output logic              jump_taken,
    output logic [WORD_W-1:0] jump_target
`ifdef ALU_WB_PERF_EN
    ,
    output logic [15:0]       perf_wr_cnt,
    output logic [15:0]       perf_jmp_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WR2  = 1'b1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_WR1  = 3'd1;
    localparam logic [2:0] OP_SWAP = 3'd2;
    localparam logic [2:0] OP_LSR  = 3'd3;
    localparam logic [2:0] OP_XSR  = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd5;

    logic [0:0]        state;
    logic [0:0]        nextState;
    logic [ADDR_W-1:0] pendAddr;
    logic [WORD_W-1:0] pendData;
    logic              loadPend;
    logic              accept;
    logic              doWrite;
    logic              doJump;
    logic [ADDR_W-1:0] wrAddr;
    logic [WORD_W-1:0] wrData;
    logic [2:0]        nextStatus;
    logic              condMet;
    logic [WORD_W-1:0] maskedResult;
    logic [WORD_W-1:0] maskedResult2;

    // Half-word mode clears the upper half of whatever goes to the register file.
    always_comb begin
        maskedResult  = in_result;
        maskedResult2 = in_result2;
        if (!in_mode) begin
            maskedResult[WORD_W-1:WORD_W/2]  = '0;
            maskedResult2[WORD_W-1:WORD_W/2] = '0;
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (in_cond)
            2'b00:   condMet = 1'b1;
            2'b01:   condMet = status[0];
            2'b10:   condMet = status[1];
            default: condMet = status[0] | status[1];
        endcase
    end

    // Decide this cycle's RF write, jump and status update; the pending SWAP write has priority.
    always_comb begin
        nextState  = state;
        nextStatus = status;
        doWrite    = 1'b0;
        doJump     = 1'b0;
        wrAddr     = '0;
        wrData     = '0;
        loadPend   = 1'b0;
        if (state == WR2) begin
            doWrite   = 1'b1;
            wrAddr    = pendAddr;
            wrData    = pendData;
            nextState = IDLE;
        end else if (accept) begin
            case (in_op)
                OP_WR1: begin
                    doWrite = 1'b1;
                    wrAddr  = in_dst;
                    wrData  = maskedResult;
                end
                OP_SWAP: begin
                    doWrite = 1'b1;
                    if (in_dst == in_dst2) begin
                        wrAddr = in_dst2;
                        wrData = maskedResult2;
                    end else begin
                        wrAddr    = in_dst;
                        wrData    = maskedResult;
                        loadPend  = 1'b1;
                        nextState = WR2;
                    end
                end
                OP_LSR:  nextStatus = in_result[2:0];
                OP_XSR:  nextStatus = status ^ in_result[2:0];
                OP_JMP:  doJump = condMet;
                default: ;
            endcase
            if (in_flag_we && (in_op == OP_NOP || in_op == OP_WR1 ||
                               in_op == OP_SWAP || in_op == OP_JMP)) begin
                nextStatus = {in_carry, in_sign, in_zero};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            status      <= 3'b000;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            jump_taken  <= 1'b0;
            jump_target <= '0;
            pendAddr    <= '0;
            pendData    <= '0;
        end else begin
            state      <= nextState;
            status     <= nextStatus;
            rf_we      <= doWrite;
            jump_taken <= doJump;
            if (doWrite) begin
                rf_addr  <= wrAddr;
                rf_wdata <= wrData;
            end
            if (doJump) begin
                jump_target <= in_result;
            end
            if (loadPend) begin
                pendAddr <= in_dst2;
                pendData <= maskedResult2;
            end
        end
    end

`ifdef ALU_WB_PERF_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_cnt  <= 16'h0000;
            perf_jmp_cnt <= 16'h0000;
        end else begin
            if (doWrite && perf_wr_cnt != 16'hFFFF) begin
                perf_wr_cnt <= perf_wr_cnt + 16'h0001;
            end
            if (doJump && perf_jmp_cnt != 16'hFFFF) begin
                perf_jmp_cnt <= perf_jmp_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed cases plus randomized traffic against a queue-based reference model.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_mode;
    logic [19:0] in_result;
    logic [19:0] in_result2;
    logic [3:0]  in_dst;
    logic [3:0]  in_dst2;
    logic        in_zero;
    logic        in_sign;
    logic        in_carry;
    logic        in_flag_we;
    logic [1:0]  in_cond;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [19:0] rf_wdata;
    logic [2:0]  status;
    logic        jump_taken;
    logic [19:0] jump_target;

    alu_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_mode(in_mode), .in_result(in_result), .in_result2(in_result2),
        .in_dst(in_dst), .in_dst2(in_dst2), .in_zero(in_zero), .in_sign(in_sign),
        .in_carry(in_carry), .in_flag_we(in_flag_we), .in_cond(in_cond),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .status(status),
        .jump_taken(jump_taken), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [19:0] data;
    } wr_t;

    int totalChecks = 0;
    int passChecks  = 0;

    // Reference model: writes still owed by the stage, architectural status, expected outputs.
    wr_t         wrQ[$];
    logic [2:0]  mStatus;
    logic        eWe;
    logic [3:0]  eAddr;
    logic [19:0] eData;
    logic        eJmp;
    logic [19:0] eTarget;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) passChecks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [19:0] maskWord(input logic mode, input logic [19:0] v);
        return mode ? v : (v & 20'h003FF);
    endfunction

    function automatic logic jumpCond(input logic [2:0] st, input logic [1:0] cond);
        logic z, s;
        z = st[0];
        s = st[1];
        if (cond == 2'b00) return 1'b1;
        if (cond == 2'b01) return z;
        if (cond == 2'b10) return s;
        return z | s;
    endfunction

    task automatic checkOutput();
        checkVal("rf_we", rf_we, eWe);
        if (eWe) begin
            checkVal("rf_addr", rf_addr, eAddr);
            checkVal("rf_wdata", rf_wdata, eData);
        end
        checkVal("jump_taken", jump_taken, eJmp);
        if (eJmp) checkVal("jump_target", jump_target, eTarget);
        checkVal("status", status, mStatus);
    endtask

    // Drive one cycle of inputs, predict the next-cycle outputs, step the clock and compare.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic mode,
                                 input logic [19:0] r, input logic [19:0] r2,
                                 input logic [3:0] d, input logic [3:0] d2,
                                 input logic z, input logic s, input logic c,
                                 input logic fwe, input logic [1:0] cond);
        logic expReady;
        logic acc;
        logic [2:0] newStatus;
        wr_t w;
        in_valid = v; in_op = op; in_mode = mode; in_result = r; in_result2 = r2;
        in_dst = d; in_dst2 = d2; in_zero = z; in_sign = s; in_carry = c;
        in_flag_we = fwe; in_cond = cond;
        #1;
        expReady = (wrQ.size() == 0) && !rst;
        checkVal("in_ready", in_ready, expReady);
        acc = v && expReady;
        eWe = 1'b0;
        eJmp = 1'b0;
        newStatus = mStatus;
        if (rst) begin
            wrQ.delete();
            newStatus = 3'b000;
        end else if (wrQ.size() > 0) begin
            w = wrQ.pop_front();
            eWe = 1'b1; eAddr = w.addr; eData = w.data;
        end else if (acc) begin
            if (op == 3'd1) begin
                eWe = 1'b1; eAddr = d; eData = maskWord(mode, r);
            end else if (op == 3'd2) begin
                eWe = 1'b1;
                if (d == d2) begin
                    eAddr = d2; eData = maskWord(mode, r2);
                end else begin
                    eAddr = d; eData = maskWord(mode, r);
                    w.addr = d2; w.data = maskWord(mode, r2);
                    wrQ.push_back(w);
                end
            end else if (op == 3'd3) begin
                newStatus = r[2:0];
            end else if (op == 3'd4) begin
                newStatus = mStatus ^ r[2:0];
            end else if (op == 3'd5) begin
                eJmp = jumpCond(mStatus, cond);
                eTarget = r;
            end
            if (fwe && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd5))
                newStatus = {c, s, z};
        end
        mStatus = newStatus;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 1'b1, 20'h0, 20'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_op = 3'd0; in_mode = 1'b0; in_result = '0; in_result2 = '0;
        in_dst = '0; in_dst2 = '0; in_zero = 1'b0; in_sign = 1'b0; in_carry = 1'b0;
        in_flag_we = 1'b0; in_cond = 2'b00;
        mStatus = 3'b000;
        @(posedge clk);
        #1;
        checkVal("ready_in_rst", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkVal("rst_rf_we", rf_we, 1'b0);
        checkVal("rst_rf_addr", rf_addr, 4'h0);
        checkVal("rst_rf_wdata", rf_wdata, 20'h0);
        checkVal("rst_status", status, 3'b000);
        checkVal("rst_jump", jump_taken, 1'b0);
        checkVal("rst_target", jump_target, 20'h0);
        checkVal("ready_after_rst", in_ready, 1'b1);

        // Case 1 and 2: full and half-word writes, flags loaded with the write.
        applyStimulus(1'b1, 3'd1, 1'b1, 20'hABCDE, 20'h0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checkVal("c1_addr", rf_addr, 4'd3);
        checkVal("c1_data", rf_wdata, 20'hABCDE);
        applyStimulus(1'b1, 3'd1, 1'b0, 20'hFFFFF, 20'h0, 4'd7, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        checkVal("c2_data", rf_wdata, 20'h003FF);
        checkVal("c2_status", status, 3'b110);

        // Case 3: two-write swap stalls one cycle, aliased swap does not.
        applyStimulus(1'b1, 3'd2, 1'b1, 20'h00011, 20'h00022, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checkVal("c3_first_addr", rf_addr, 4'd1);
        checkVal("c3_stall", in_ready, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b1, 20'h12345, 20'h0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checkVal("c3_second_addr", rf_addr, 4'd2);
        checkVal("c3_second_data", rf_wdata, 20'h00022);
        applyStimulus(1'b1, 3'd2, 1'b1, 20'h00011, 20'h00022, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checkVal("c3_alias_data", rf_wdata, 20'h00022);
        checkVal("c3_alias_ready", in_ready, 1'b1);

        // Case 4: LSR sets zero so JMP-on-zero is taken; XSR clears it again.
        applyStimulus(1'b1, 3'd3, 1'b1, 20'h00001, 20'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        applyStimulus(1'b1, 3'd5, 1'b1, 20'h00100, 20'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        checkVal("c4_taken", jump_taken, 1'b1);
        checkVal("c4_target", jump_target, 20'h00100);
        applyStimulus(1'b1, 3'd4, 1'b1, 20'h00001, 20'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b1, 3'd5, 1'b1, 20'h00200, 20'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        checkVal("c4_not_taken", jump_taken, 1'b0);

        // Case 5: a JMP judges the old status even while loading new flags.
        applyStimulus(1'b1, 3'd5, 1'b1, 20'h00300, 20'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        checkVal("c5_not_taken", jump_taken, 1'b0);
        applyStimulus(1'b1, 3'd5, 1'b1, 20'h00400, 20'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        checkVal("c5_taken", jump_taken, 1'b1);

        // Case 6: reset during the second swap write drops it.
        applyStimulus(1'b1, 3'd2, 1'b1, 20'h00033, 20'h00044, 4'd6, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        idleCycle();
        checkVal("c6_addr", rf_addr, 4'h0);
        checkVal("c6_data", rf_wdata, 20'h0);
        rst = 1'b0;
        #1;
        checkVal("c6_ready", in_ready, 1'b1);

        // Randomized traffic, with the occasional reset and biased dst aliasing.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] d;
            logic [3:0] d2;
            d  = 4'($urandom_range(0, 15));
            d2 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 60) == 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 20'($urandom), 20'($urandom), d, d2,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)));
        end
        rst = 1'b0;
        idleCycle();
        idleCycle();

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
